// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: registered valid/ready stage with a one-entry skid buffer
// and synchronous flush, placed after the 2:1 datapath mux.
//
// Ports:
//   CLK, CLRN           clock, async active-low reset
//   D, IN_VALID         upstream word and its valid
//   IN_READY            stage can accept (decoded from state only)
//   FLUSH               synchronous discard of held entries
//   Q, OUT_VALID        registered output word and valid
//   OUT_READY           downstream accepts Q
//   STALL_CNT           saturating stall counter (PIPE_SKID_STALL_CNT_EN)
//
// Optional feature macro: PIPE_SKID_STALL_CNT_EN
module pipe_skid_reg #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             CLRN,
   input  logic [WIDTH-1:0] D,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic             FLUSH,
   output logic [WIDTH-1:0] Q,
   output logic             OUT_VALID,
   input  logic             OUT_READY
`ifdef PIPE_SKID_STALL_CNT_EN
   ,
   output logic [15:0]      STALL_CNT
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] m_q;
   logic [WIDTH-1:0] s_q;
   logic             load_m_d;
   logic             load_m_s;
   logic             load_s_d;
   logic             in_fire;
   logic             out_fire;

   // Handshake outputs come straight from the state register, so no
   // combinational path exists from OUT_READY to IN_READY.
   assign OUT_VALID = (state_q != EMPTY);
   assign IN_READY  = (state_q != TWO);
   assign Q         = m_q;

   assign in_fire  = IN_VALID & IN_READY;
   assign out_fire = OUT_VALID & OUT_READY;

   always_comb begin
      state_d  = state_q;
      load_m_d = 1'b0;
      load_m_s = 1'b0;
      load_s_d = 1'b0;
      if (FLUSH) begin
         // Flush wins over any concurrent fire; data regs keep stale values.
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  load_m_d = 1'b1;
                  state_d  = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  load_m_d = 1'b1;
               end else if (in_fire) begin
                  load_s_d = 1'b1;
                  state_d  = TWO;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (out_fire) begin
                  load_m_s = 1'b1;
                  state_d  = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge CLRN) begin
      if (!CLRN) begin
         state_q <= EMPTY;
         m_q     <= '0;
         s_q     <= '0;
      end else begin
         state_q <= state_d;
         if (load_m_d) begin
            m_q <= D;
         end else if (load_m_s) begin
            m_q <= s_q;
         end
         if (load_s_d) begin
            s_q <= D;
         end
      end
   end

`ifdef PIPE_SKID_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge CLK or negedge CLRN) begin
      if (!CLRN) begin
         stall_q <= '0;
      end else if (FLUSH) begin
         stall_q <= '0;
      end else if (OUT_VALID && !OUT_READY && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign STALL_CNT = stall_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed stimulus with an expected-word queue,
// checked by an independent output monitor.
module tb_pipe_skid_reg;

   logic        CLK;
   logic        CLRN;
   logic [31:0] D;
   logic        IN_VALID;
   logic        IN_READY;
   logic        FLUSH;
   logic [31:0] Q;
   logic        OUT_VALID;
   logic        OUT_READY;
`ifdef PIPE_SKID_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int compared = 0;
   int errors   = 0;
   logic [31:0] exp_q[$];

   pipe_skid_reg #(.WIDTH(32)) dut (
      .CLK       (CLK),
      .CLRN      (CLRN),
      .D         (D),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .FLUSH     (FLUSH),
      .Q         (Q),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY)
`ifdef PIPE_SKID_STALL_CNT_EN
      ,
      .STALL_CNT (stall_cnt)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Present a word; record it as expected only if it will be accepted.
   task automatic drive(input logic [31:0] w);
      D        = w;
      IN_VALID = 1'b1;
      if (IN_READY && !FLUSH) exp_q.push_back(w);
   endtask

   // Monitor: every output fire must match the oldest expected word.
   always @(negedge CLK) begin
      if (CLRN && !FLUSH && OUT_VALID && OUT_READY) begin
         compared++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got %h expected none", Q);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (Q !== e) begin
               errors++;
               $display("FAIL out_order: got %h expected %h", Q, e);
            end
         end
      end
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: got running expected done");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, errors);
      $finish;
   end

   initial begin
      CLRN      = 1'b1;
      D         = '0;
      IN_VALID  = 1'b0;
      FLUSH     = 1'b0;
      OUT_READY = 1'b0;
      #1 CLRN = 1'b0;
      #1;
      chk("rst_q", Q, 32'h0);
      chk("rst_ov", {31'd0, OUT_VALID}, 32'd0);
      chk("rst_ir", {31'd0, IN_READY}, 32'd1);
      repeat (3) step();
      chk("rst_q2", Q, 32'h0);
      chk("rst_ov2", {31'd0, OUT_VALID}, 32'd0);
      chk("rst_ir2", {31'd0, IN_READY}, 32'd1);
      CLRN = 1'b1;
      step();
      chk("idle_q", Q, 32'h0);
      chk("idle_ov", {31'd0, OUT_VALID}, 32'd0);
      chk("idle_ir", {31'd0, IN_READY}, 32'd1);

      // Single transfer
      OUT_READY = 1'b1;
      drive(32'h8b);
      step();
      IN_VALID = 1'b0;
      chk("single_ov", {31'd0, OUT_VALID}, 32'd1);
      chk("single_q", Q, 32'h8b);
      step();
      chk("single_ov_end", {31'd0, OUT_VALID}, 32'd0);

      // Streaming
      begin
         logic [31:0] words[4];
         words = '{32'h8b, 32'h5f, 32'h8b, 32'h5f};
         for (int i = 0; i < 4; i++) begin
            drive(words[i]);
            step();
            chk("stream_ir", {31'd0, IN_READY}, 32'd1);
            chk("stream_q", Q, words[i]);
         end
         IN_VALID = 1'b0;
         step();
         step();
      end

      // Backpressure / skid
      OUT_READY = 1'b0;
      drive(32'h8b);
      step();
      drive(32'h5f);
      step();
      IN_VALID = 1'b0;
      chk("skid_ir", {31'd0, IN_READY}, 32'd0);
      chk("skid_q", Q, 32'h8b);
      chk("skid_ov", {31'd0, OUT_VALID}, 32'd1);
      step();
      chk("skid_hold_q", Q, 32'h8b);
      OUT_READY = 1'b1;
      step();
      chk("skid_q2", Q, 32'h5f);
      chk("skid_ir2", {31'd0, IN_READY}, 32'd1);
      step();
      chk("skid_ov_end", {31'd0, OUT_VALID}, 32'd0);

      // Flush priority from TWO
      OUT_READY = 1'b0;
      drive(32'h11);
      step();
      drive(32'h22);
      step();
      chk("fl_pre_ir", {31'd0, IN_READY}, 32'd0);
      FLUSH = 1'b1;
      exp_q.delete();
      drive(32'h1234);
      OUT_READY = 1'b1;
      step();
      FLUSH    = 1'b0;
      IN_VALID = 1'b0;
      chk("fl_ov", {31'd0, OUT_VALID}, 32'd0);
      chk("fl_ir", {31'd0, IN_READY}, 32'd1);
      chk("fl_stale_q", Q, 32'h11);
      step();
      chk("fl_ov2", {31'd0, OUT_VALID}, 32'd0);
      drive(32'haa);
      step();
      IN_VALID = 1'b0;
      chk("fl_recover_q", Q, 32'haa);
      step();

      // Async reset while in TWO
      OUT_READY = 1'b0;
      drive(32'h33);
      step();
      drive(32'h44);
      step();
      IN_VALID = 1'b0;
      chk("ar_pre_ir", {31'd0, IN_READY}, 32'd0);
      #2;
      CLRN = 1'b0;
      exp_q.delete();
      #1;
      chk("ar_ov", {31'd0, OUT_VALID}, 32'd0);
      chk("ar_q", Q, 32'h0);
      chk("ar_ir", {31'd0, IN_READY}, 32'd1);
`ifdef PIPE_SKID_STALL_CNT_EN
      chk("ar_stall", {16'd0, stall_cnt}, 32'd0);
`endif
      step();
      step();
      CLRN = 1'b1;
      drive(32'h55);
      step();
      IN_VALID = 1'b0;
      repeat (5) step();
      chk("stall_q", Q, 32'h55);
      chk("stall_ov", {31'd0, OUT_VALID}, 32'd1);
`ifdef PIPE_SKID_STALL_CNT_EN
      chk("stall_cnt5", {16'd0, stall_cnt}, 32'd5);
`endif
      OUT_READY = 1'b1;
      step();
      OUT_READY = 1'b0;
      step();
      chk("drain_left", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, errors);
      $finish;
   end

endmodule
